serial_adder: RTL and testbench

SERIAL_ADDER -- requirements
Module: serial_adder

---
 rtl/serial_adder_pkg.sv | 18 +
 rtl/serial_adder_if.sv | 37 +++
 rtl/serial_adder_full_adder.sv | 13 +
 rtl/serial_adder.sv | 120 ++++++++++++
 tb/tb_serial_adder.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/serial_adder_pkg.sv
// Shared constants for the bit-serial adder: state codes, default width, counter sizing.
package serial_adder_pkg;

    localparam int unsigned SA_DEFAULT_WIDTH = 8;
    localparam int unsigned SA_CNT_W         = $clog2(SA_DEFAULT_WIDTH);

    typedef logic [1:0] sa_state_t;

    localparam sa_state_t ST_IDLE  = 2'd0;
    localparam sa_state_t ST_SHIFT = 2'd1;
    localparam sa_state_t ST_DONE  = 2'd2;

    // Counter must hold 0..WIDTH-1; never narrower than one bit.
    function automatic int unsigned sa_cnt_width(input int unsigned w);
        return (w < 2) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/serial_adder_if.sv
// Operand/result handshake bundle for serial_adder; ovf exists only with SERIAL_ADDER_OVF_EN.
interface serial_adder_if
    import serial_adder_pkg::*;
#(
    parameter int unsigned WIDTH = SA_DEFAULT_WIDTH
);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
`ifdef SERIAL_ADDER_OVF_EN
    logic             ovf;
`endif

    modport master (
        output in_valid, a, b, cin, out_ready,
`ifdef SERIAL_ADDER_OVF_EN
        input  ovf,
`endif
        input  in_ready, out_valid, sum, cout
    );

    modport slave (
        input  in_valid, a, b, cin, out_ready,
`ifdef SERIAL_ADDER_OVF_EN
        output ovf,
`endif
        output in_ready, out_valid, sum, cout
    );

endinterface

// File: rtl/serial_adder_full_adder.sv
// Combinational 1-bit full adder cell used by the serial adder datapath.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic sum,
    output logic carry
);

    assign sum   = a ^ b ^ c;
    assign carry = (a & b) | (a & c) | (b & c);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder cell, WIDTH shift cycles per operation.
// Optional signed-overflow output enabled by defining SERIAL_ADDER_OVF_EN.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int unsigned WIDTH = SA_DEFAULT_WIDTH
) (
    input  logic          clk,
    input  logic          rst_n,
    serial_adder_if.slave bus
);

    localparam int unsigned          CNT_W = sa_cnt_width(WIDTH);
    localparam logic [CNT_W-1:0]     LAST  = CNT_W'(WIDTH - 1);

    sa_state_t        state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
`ifdef SERIAL_ADDER_OVF_EN
    logic             ovf_q, ovf_d;
`endif

    logic fa_sum;
    logic fa_carry;

    full_adder u_fa (
        .a     (a_q[0]),
        .b     (b_q[0]),
        .c     (carry_q),
        .sum   (fa_sum),
        .carry (fa_carry)
    );

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        cnt_d   = cnt_q;
`ifdef SERIAL_ADDER_OVF_EN
        ovf_d   = ovf_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    a_d     = bus.a;
                    b_d     = bus.b;
                    carry_d = bus.cin;
                    cnt_d   = '0;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                sum_d   = {fa_sum, sum_q[WIDTH-1:1]};
                a_d     = a_q >> 1;
                b_d     = b_q >> 1;
                carry_d = fa_carry;
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == LAST) begin
                    cout_d  = fa_carry;
`ifdef SERIAL_ADDER_OVF_EN
                    // carry_q here is the carry into the MSB
                    ovf_d   = carry_q ^ fa_carry;
`endif
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (bus.out_ready) begin
`ifdef SERIAL_ADDER_OVF_EN
                    ovf_d   = 1'b0;
`endif
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            cnt_q   <= '0;
`ifdef SERIAL_ADDER_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            cnt_q   <= cnt_d;
`ifdef SERIAL_ADDER_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign bus.in_ready  = (state_q == ST_IDLE);
    assign bus.out_valid = (state_q == ST_DONE);
    assign bus.sum       = sum_q;
    assign bus.cout      = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
    assign bus.ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_serial_adder.sv
// Directed self-checking bench for serial_adder (WIDTH=8); ovf checks under SERIAL_ADDER_OVF_EN.
module tb_serial_adder;

    localparam int W = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;

    serial_adder_if #(.WIDTH(W)) intf ();

    serial_adder #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (intf.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one operand set from IDLE and wait (bounded) for out_valid; leaves the DUT in DONE.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                          output logic [W-1:0] s, output logic co, output int lat);
        intf.a = a; intf.b = b; intf.cin = c;
        intf.in_valid = 1'b1;
        intf.out_ready = 1'b0;
        tick();
        intf.in_valid = 1'b0;
        lat = 0;
        while (!intf.out_valid && lat < 40) begin
            tick();
            lat++;
        end
        s = intf.sum;
        co = intf.cout;
    endtask

    task automatic handoff();
        intf.out_ready = 1'b1;
        tick();
        intf.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        checks++; if (intf.in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", intf.in_ready); end
        checks++; if (intf.out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", intf.out_valid); end
        checks++; if (intf.sum !== 8'h00) begin failures++; $display("FAIL reset_sum got=%h exp=00", intf.sum); end
        checks++; if (intf.cout !== 1'b0) begin failures++; $display("FAIL reset_cout got=%b exp=0", intf.cout); end
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        logic [W-1:0] va [3] = '{8'h0F, 8'hFF, 8'hFF};
        logic [W-1:0] vb [3] = '{8'h01, 8'h01, 8'hFF};
        logic         vc [3] = '{1'b0, 1'b0, 1'b1};
        logic [W-1:0] es [3] = '{8'h10, 8'h00, 8'hFF};
        logic         ec [3] = '{1'b0, 1'b1, 1'b1};
        logic [W-1:0] s;
        logic co;
        int lat;
        for (int i = 0; i < 3; i++) begin
            run_op(va[i], vb[i], vc[i], s, co, lat);
            checks++; if (lat !== W) begin failures++; $display("FAIL basic_latency[%0d] got=%0d exp=%0d", i, lat, W); end
            checks++; if (s !== es[i]) begin failures++; $display("FAIL basic_sum[%0d] got=%h exp=%h", i, s, es[i]); end
            checks++; if (co !== ec[i]) begin failures++; $display("FAIL basic_cout[%0d] got=%b exp=%b", i, co, ec[i]); end
            checks++; if (intf.in_ready !== 1'b0) begin failures++; $display("FAIL basic_in_ready_done[%0d] got=%b exp=0", i, intf.in_ready); end
            handoff();
            checks++; if (intf.in_ready !== 1'b1 || intf.out_valid !== 1'b0) begin
                failures++; $display("FAIL basic_handoff[%0d] in_ready=%b out_valid=%b exp 1/0", i, intf.in_ready, intf.out_valid);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [W-1:0] s;
        logic co;
        int lat;
        run_op(8'h55, 8'h22, 1'b0, s, co, lat);
        checks++; if (s !== 8'h77) begin failures++; $display("FAIL bp_sum got=%h exp=77", s); end
        intf.in_valid = 1'b1;
        intf.a = 8'h11; intf.b = 8'h11; intf.cin = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++; if (intf.out_valid !== 1'b1 || intf.in_ready !== 1'b0 || intf.sum !== 8'h77 || intf.cout !== 1'b0) begin
                failures++;
                $display("FAIL bp_hold[%0d] out_valid=%b in_ready=%b sum=%h cout=%b exp 1/0/77/0",
                         i, intf.out_valid, intf.in_ready, intf.sum, intf.cout);
            end
        end
        intf.in_valid = 1'b0;
        handoff();
        checks++; if (intf.in_ready !== 1'b1 || intf.out_valid !== 1'b0) begin
            failures++; $display("FAIL bp_release in_ready=%b out_valid=%b exp 1/0", intf.in_ready, intf.out_valid);
        end
    endtask

    task automatic test_reset_mid_shift();
        logic [W-1:0] s;
        logic co;
        int lat;
        int seen;
        intf.a = 8'hAA; intf.b = 8'h55; intf.cin = 1'b1;
        intf.in_valid = 1'b1;
        tick();
        intf.in_valid = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        rst_n = 1'b0;
        #1;
        checks++; if (intf.in_ready !== 1'b1 || intf.out_valid !== 1'b0 || intf.sum !== 8'h00 || intf.cout !== 1'b0) begin
            failures++;
            $display("FAIL midrst_values in_ready=%b out_valid=%b sum=%h cout=%b exp 1/0/00/0",
                     intf.in_ready, intf.out_valid, intf.sum, intf.cout);
        end
        tick();
        rst_n = 1'b1;
        seen = 0;
        intf.out_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (intf.out_valid) seen++;
        end
        intf.out_ready = 1'b0;
        checks++; if (seen !== 0) begin failures++; $display("FAIL midrst_no_result got=%0d valid cycles exp=0", seen); end
        run_op(8'h12, 8'h34, 1'b0, s, co, lat);
        checks++; if (s !== 8'h46 || co !== 1'b0) begin failures++; $display("FAIL midrst_next_op sum=%h cout=%b exp 46/0", s, co); end
        handoff();
    endtask

`ifdef SERIAL_ADDER_OVF_EN
    task automatic test_ovf();
        logic [W-1:0] s;
        logic co;
        int lat;
        run_op(8'h7F, 8'h01, 1'b0, s, co, lat);
        checks++; if (s !== 8'h80 || co !== 1'b0 || intf.ovf !== 1'b1) begin
            failures++; $display("FAIL ovf_7f_01 sum=%h cout=%b ovf=%b exp 80/0/1", s, co, intf.ovf);
        end
        handoff();
        checks++; if (intf.ovf !== 1'b0) begin failures++; $display("FAIL ovf_clear got=%b exp=0", intf.ovf); end
        run_op(8'h80, 8'h80, 1'b0, s, co, lat);
        checks++; if (s !== 8'h00 || co !== 1'b1 || intf.ovf !== 1'b1) begin
            failures++; $display("FAIL ovf_80_80 sum=%h cout=%b ovf=%b exp 00/1/1", s, co, intf.ovf);
        end
        handoff();
        run_op(8'h01, 8'h01, 1'b0, s, co, lat);
        checks++; if (s !== 8'h02 || intf.ovf !== 1'b0) begin
            failures++; $display("FAIL ovf_01_01 sum=%h ovf=%b exp 02/0", s, intf.ovf);
        end
        handoff();
    endtask
`endif

    task automatic test_back_to_back();
        logic [W:0] exp;
        int prev_acc;
        int acc;
        int n;
        logic [W-1:0] ca;
        logic [W-1:0] cb;
        logic         cc;
        ca = W'($urandom); cb = W'($urandom); cc = 1'($urandom);
        intf.a = ca; intf.b = cb; intf.cin = cc;
        intf.in_valid = 1'b1;
        intf.out_ready = 1'b1;
        prev_acc = 0;
        for (int i = 0; i < 1000; i++) begin
            n = 0;
            while (!intf.in_ready && n < 20) begin tick(); n++; end
            checks++; if (intf.in_ready !== 1'b1) begin failures++; $display("FAIL b2b_ready_timeout[%0d] got=%b exp=1", i, intf.in_ready); break; end
            tick();
            acc = cyc;
            if (i > 0) begin
                checks++; if (acc - prev_acc !== W + 2) begin failures++; $display("FAIL b2b_spacing[%0d] got=%0d exp=%0d", i, acc - prev_acc, W + 2); end
            end
            prev_acc = acc;
            exp = {1'b0, ca} + {1'b0, cb} + {{W{1'b0}}, cc};
            // New operands land during SHIFT and must not disturb the running add.
            ca = W'($urandom); cb = W'($urandom); cc = 1'($urandom);
            intf.a = ca; intf.b = cb; intf.cin = cc;
            n = 0;
            while (!intf.out_valid && n < 40) begin tick(); n++; end
            checks++; if ({intf.cout, intf.sum} !== exp) begin
                failures++; $display("FAIL b2b_result[%0d] got=%b_%h exp=%b_%h", i, intf.cout, intf.sum, exp[W], exp[W-1:0]);
            end
        end
        intf.in_valid = 1'b0;
        tick();
        tick();
        intf.out_ready = 1'b0;
    endtask

    initial begin
        intf.in_valid = 1'b0;
        intf.out_ready = 1'b0;
        intf.a = '0;
        intf.b = '0;
        intf.cin = 1'b0;
        test_reset();
        test_basic();
        test_backpressure();
        test_reset_mid_shift();
`ifdef SERIAL_ADDER_OVF_EN
        test_ovf();
`endif
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
